// File: rtl/opnd_skew_feeder_if.sv
// Bus bundle for the operand skew feeder: control from the array
// controller, the operand SRAM read port and the skewed operand output.
interface opnd_skew_feeder_if #(
    parameter int NUM_LANES   = 32,
    parameter int OPND_BWIDTH = 8,
    parameter int ADDR_BWIDTH = 10,
    parameter int LEN_BWIDTH  = 10,
    parameter int ROW_BWIDTH  = NUM_LANES * OPND_BWIDTH
);
    logic                   STALL;
    logic                   START_in;
    logic [ADDR_BWIDTH-1:0] BASE_ADDR_in;
    logic [LEN_BWIDTH-1:0]  LEN_in;
    logic                   RD_EN_out;
    logic [ADDR_BWIDTH-1:0] RD_ADDR_out;
    logic [ROW_BWIDTH-1:0]  RD_DATA_in;
    logic [ROW_BWIDTH-1:0]  DATA_out;
    logic [NUM_LANES-1:0]   VALID_out;
    logic                   BUSY_out;
    logic                   DONE_out;

    // Controller / SRAM / array side
    modport master (
        output STALL, START_in, BASE_ADDR_in, LEN_in, RD_DATA_in,
        input  RD_EN_out, RD_ADDR_out, DATA_out, VALID_out, BUSY_out, DONE_out
    );

    // Feeder side
    modport slave (
        input  STALL, START_in, BASE_ADDR_in, LEN_in, RD_DATA_in,
        output RD_EN_out, RD_ADDR_out, DATA_out, VALID_out, BUSY_out, DONE_out
    );
endinterface

// File: rtl/opnd_skew_feeder.sv
// Operand feeder for one edge of the systolic PE array. Streams LEN rows
// from the operand SRAM and presents them with a diagonal skew: lane i is
// delayed i cycles, with a matching per-lane valid bit. A global STALL
// freezes everything except a one-entry hold register that catches read
// data already in flight.
module opnd_skew_feeder #(
    parameter int NUM_LANES   = 32,
    parameter int OPND_BWIDTH = 8,
    parameter int ADDR_BWIDTH = 10,
    parameter int LEN_BWIDTH  = 10
) (
    input logic CLK,
    input logic RST,
    opnd_skew_feeder_if.slave bus
);
    localparam int ROW_BWIDTH = NUM_LANES * OPND_BWIDTH;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t                 state_q;
    logic [ADDR_BWIDTH-1:0] rdAddr_q;
    logic [LEN_BWIDTH-1:0]  remaining_q;
    logic                   pending_q;
    logic                   holdValid_q;
    logic [ROW_BWIDTH-1:0]  holdData_q;
    logic                   rowValid_q;
    logic [ROW_BWIDTH-1:0]  rowData_q;

    logic                   rdEn;
    logic                   drained;
    logic [NUM_LANES-1:0]   laneValid;
    logic [NUM_LANES-1:0]   laneBusyNext;
    logic [ROW_BWIDTH-1:0]  dataOut;

    // A read goes out every non-stalled READ cycle. The hold register can
    // only fill during a stall, and it empties in the very next non-stalled
    // cycle, so it is never full when a read is issued.
    assign rdEn            = (state_q == READ) && !bus.STALL;
    assign bus.RD_EN_out   = rdEn;
    assign bus.RD_ADDR_out = rdAddr_q;
    assign bus.BUSY_out    = (state_q != IDLE);
    assign bus.DONE_out    = (state_q == FIN);
    assign bus.VALID_out   = laneValid;
    assign bus.DATA_out    = dataOut;

    // Drain finishes when nothing is in flight and no lane will still hold
    // a valid operand after this edge, so DONE follows the last operand.
    assign drained = !pending_q && !holdValid_q && (laneBusyNext == '0);

    // Sequencer: accepts a job, issues LEN reads, waits for the skew to empty
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rdAddr_q    <= '0;
            remaining_q <= '0;
        end else if (!bus.STALL) begin
            case (state_q)
                IDLE: begin
                    if (bus.START_in) begin
                        rdAddr_q    <= bus.BASE_ADDR_in;
                        remaining_q <= bus.LEN_in;
                        state_q     <= (bus.LEN_in == '0) ? FIN : READ;
                    end
                end
                READ: begin
                    rdAddr_q    <= rdAddr_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
                    if (remaining_q == LEN_BWIDTH'(1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Return path: SRAM data lands in row_q, or in the hold register if the
    // return cycle is stalled; the held row is forwarded once the stall lifts
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q   <= 1'b0;
            holdValid_q <= 1'b0;
            holdData_q  <= '0;
            rowValid_q  <= 1'b0;
            rowData_q   <= '0;
        end else if (bus.STALL) begin
            if (pending_q) begin
                holdData_q  <= bus.RD_DATA_in;
                holdValid_q <= 1'b1;
                pending_q   <= 1'b0;
            end
        end else begin
            pending_q <= rdEn;
            if (holdValid_q) begin
                rowData_q   <= holdData_q;
                rowValid_q  <= 1'b1;
                holdValid_q <= 1'b0;
            end else if (pending_q) begin
                rowData_q  <= bus.RD_DATA_in;
                rowValid_q <= 1'b1;
            end else begin
                rowValid_q <= 1'b0;
            end
        end
    end

    // Lane i of row_q runs through i registers; lane 0 is the MSB slice
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int LO = (NUM_LANES - 1 - i) * OPND_BWIDTH;

        if (i == 0) begin : g_direct
            assign laneValid[i]                = rowValid_q;
            assign laneBusyNext[i]             = 1'b0;
            assign dataOut[LO +: OPND_BWIDTH]  = rowValid_q ? rowData_q[LO +: OPND_BWIDTH] : '0;
        end else begin : g_pipe
            localparam logic [i-1:0] KEEP_MASK = {i{1'b1}} >> 1;

            logic [OPND_BWIDTH-1:0] pipeData_q [i];
            logic [i-1:0]           pipeValid_q;

            // Data and valid shift together so a lane's valid always
            // describes the operand beside it
            always_ff @(posedge CLK) begin
                if (RST) begin
                    pipeValid_q <= '0;
                    for (int j = 0; j < i; j++) begin
                        pipeData_q[j] <= '0;
                    end
                end else if (!bus.STALL) begin
                    pipeData_q[0]  <= rowData_q[LO +: OPND_BWIDTH];
                    pipeValid_q[0] <= rowValid_q;
                    for (int j = 1; j < i; j++) begin
                        pipeData_q[j]  <= pipeData_q[j-1];
                        pipeValid_q[j] <= pipeValid_q[j-1];
                    end
                end
            end

            assign laneValid[i]               = pipeValid_q[i-1];
            assign laneBusyNext[i]            = rowValid_q | (|(pipeValid_q & KEEP_MASK));
            assign dataOut[LO +: OPND_BWIDTH] = pipeValid_q[i-1] ? pipeData_q[i-1] : '0;
        end
    end
endmodule
